// File: rtl/z80_pkg.sv
// Shared definitions for the Z80 SRAM memory controller: FSM encoding,
// default write-protect boundary and legal wait-cycle range.
package z80_pkg;

    typedef enum logic [1:0] {
        PARK    = 2'd0,
        ACCESS  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] ROM_TOP_DEFAULT = 16'h3FFF;
    localparam int unsigned WAIT_MIN        = 1;
    localparam int unsigned WAIT_MAX        = 7;

endpackage

// File: rtl/z80_memctl.sv
// Z80 core to asynchronous SRAM bridge: one core step per WAIT_CYCLES+2 clocks.
// Define Z80_MEMCTL_ROM_WP_EN to block writes at or below ROM_TOP and flag them.
module z80_memctl
    import z80_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] ROM_TOP     = ROM_TOP_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        RUN,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_W,
    output logic [7:0]  CPU_DI,
    output logic        HOLD,
    output logic [15:0] SRAM_A,
    input  logic [7:0]  SRAM_DQ_I,
    output logic [7:0]  SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        WP_FAULT
);

    if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $fatal(1, "z80_memctl: WAIT_CYCLES must be within 1..7");
    end

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t      state;
    state_t      next;
    logic [2:0]  cnt;
    logic        wr_flag;
    logic        we_flag;
    logic        prot;
    logic        nxt_wr;
    logic        nxt_we;

`ifdef Z80_MEMCTL_ROM_WP_EN
    logic fault;

    assign prot = (CPU_A <= ROM_TOP);

    always_ff @(posedge CLOCK) begin
        if (RESET)
            fault <= 1'b0;
        else if (state == ACCESS && CPU_W && prot)
            fault <= 1'b1;
    end

    assign WP_FAULT = fault;
`else
    logic unused_rom_top;

    assign prot           = 1'b0;
    assign unused_rom_top = ^ROM_TOP;
    assign WP_FAULT       = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET)
            state <= PARK;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            PARK:    if (RUN) next = ACCESS;
            ACCESS:  next = WAIT;
            WAIT:    if (cnt == 3'd1) next = RELEASE;
            RELEASE: next = RUN ? ACCESS : PARK;
            default: next = PARK;
        endcase
    end

    // Strobes are registered from the next state, so the access type must be
    // taken straight from the core while it is being latched in ACCESS.
    always_comb begin
        nxt_wr = wr_flag;
        nxt_we = we_flag;
        if (state == ACCESS) begin
            nxt_wr = CPU_W;
            nxt_we = CPU_W && !prot;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt        <= '0;
            wr_flag    <= 1'b0;
            we_flag    <= 1'b0;
            SRAM_A     <= '0;
            SRAM_DQ_O  <= '0;
            CPU_DI     <= '0;
            HOLD       <= 1'b0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
        end else begin
            HOLD       <= (next == RELEASE);
            SRAM_OE_N  <= !(next == WAIT && !nxt_wr);
            SRAM_WE_N  <= !(next == WAIT && nxt_we);
            SRAM_DQ_OE <= (next == WAIT && nxt_we);
            case (state)
                ACCESS: begin
                    SRAM_A    <= CPU_A;
                    SRAM_DQ_O <= CPU_DO;
                    wr_flag   <= CPU_W;
                    we_flag   <= CPU_W && !prot;
                    cnt       <= WAIT_LOAD;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1 && !wr_flag)
                        CPU_DI <= SRAM_DQ_I;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_memctl.sv
// Directed self-checking bench for z80_memctl (WAIT_CYCLES=2 and 7 instances).
module tb_z80_memctl;

    logic        CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic        RESET, RUN, CPU_W;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic [7:0]  CPU_DI;
    logic        HOLD;
    logic [15:0] SRAM_A;
    logic [7:0]  SRAM_DQ_I, SRAM_DQ_O;
    logic        SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N, WP_FAULT;

    logic        reset7, run7, w7;
    logic [15:0] a7;
    logic [7:0]  do7, di7;
    logic        hold7;
    logic [15:0] sram_a7;
    logic [7:0]  dq_i7, dq_o7;
    logic        dq_oe7, we_n7, oe_n7, wp7;

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [7:0] sram_data(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h3E;
    endfunction

    assign SRAM_DQ_I = SRAM_OE_N ? 8'hFF : sram_data(SRAM_A);
    assign dq_i7     = oe_n7 ? 8'hFF : sram_data(sram_a7);

    z80_memctl #(.WAIT_CYCLES(2), .ROM_TOP(16'h3FFF)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN),
        .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_W(CPU_W), .CPU_DI(CPU_DI),
        .HOLD(HOLD), .SRAM_A(SRAM_A), .SRAM_DQ_I(SRAM_DQ_I),
        .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .WP_FAULT(WP_FAULT)
    );

    z80_memctl #(.WAIT_CYCLES(7)) dut7 (
        .CLOCK(CLOCK), .RESET(reset7), .RUN(run7),
        .CPU_A(a7), .CPU_DO(do7), .CPU_W(w7), .CPU_DI(di7),
        .HOLD(hold7), .SRAM_A(sram_a7), .SRAM_DQ_I(dq_i7),
        .SRAM_DQ_O(dq_o7), .SRAM_DQ_OE(dq_oe7),
        .SRAM_WE_N(we_n7), .SRAM_OE_N(oe_n7), .WP_FAULT(wp7)
    );

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset;
        RESET  = 1'b1;
        RUN    = 1'b0;
        CPU_W  = 1'b0;
        CPU_A  = '0;
        CPU_DO = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset;
        RESET = 1'b1; RUN = 1'b1; CPU_A = 16'hFFFF; CPU_W = 1'b1; CPU_DO = 8'hFF;
        repeat (3) tick();
        total_cnt++; if (HOLD !== 1'b0) $display("FAIL reset_hold: got %b expected 0", HOLD); else pass_cnt++;
        total_cnt++; if (CPU_DI !== 8'h00) $display("FAIL reset_cpu_di: got %h expected 00", CPU_DI); else pass_cnt++;
        total_cnt++; if (SRAM_A !== 16'h0000) $display("FAIL reset_sram_a: got %h expected 0000", SRAM_A); else pass_cnt++;
        total_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL reset_we_n: got %b expected 1", SRAM_WE_N); else pass_cnt++;
        total_cnt++; if (SRAM_OE_N !== 1'b1) $display("FAIL reset_oe_n: got %b expected 1", SRAM_OE_N); else pass_cnt++;
        total_cnt++; if (SRAM_DQ_OE !== 1'b0) $display("FAIL reset_dq_oe: got %b expected 0", SRAM_DQ_OE); else pass_cnt++;
        total_cnt++; if (WP_FAULT !== 1'b0) $display("FAIL reset_wp_fault: got %b expected 0", WP_FAULT); else pass_cnt++;
        RUN = 1'b0; CPU_W = 1'b0;
    endtask

    task automatic test_first_read;
        logic exp;
        do_reset();
        CPU_A = 16'h0000; CPU_W = 1'b0; RUN = 1'b1; RESET = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp = (c == 4);
            total_cnt++; if (HOLD !== exp) $display("FAIL first_read_hold c%0d: got %b expected %b", c, HOLD, exp); else pass_cnt++;
            exp = !(c == 2 || c == 3);
            total_cnt++; if (SRAM_OE_N !== exp) $display("FAIL first_read_oe_n c%0d: got %b expected %b", c, SRAM_OE_N, exp); else pass_cnt++;
            if (c == 4) begin
                total_cnt++; if (CPU_DI !== 8'h3E) $display("FAIL first_read_data: got %h expected 3e", CPU_DI); else pass_cnt++;
            end
        end
        RUN = 1'b0;
    endtask

    task automatic test_write;
        logic exp;
        int   we_low;
        we_low = 0;
        do_reset();
        CPU_A = 16'h1234; CPU_W = 1'b0; RUN = 1'b1; RESET = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 4) begin
                total_cnt++; if (CPU_DI !== 8'h18) $display("FAIL write_pre_read: got %h expected 18", CPU_DI); else pass_cnt++;
                CPU_A = 16'h8000; CPU_DO = 8'hA5; CPU_W = 1'b1;
            end
            if (c >= 5) begin
                if (!SRAM_WE_N) we_low++;
                exp = !(c == 6 || c == 7);
                total_cnt++; if (SRAM_WE_N !== exp) $display("FAIL write_we_n c%0d: got %b expected %b", c, SRAM_WE_N, exp); else pass_cnt++;
                total_cnt++; if (SRAM_DQ_OE !== !exp) $display("FAIL write_dq_oe c%0d: got %b expected %b", c, SRAM_DQ_OE, !exp); else pass_cnt++;
                if (!exp) begin
                    total_cnt++; if (SRAM_DQ_O !== 8'hA5) $display("FAIL write_dq_o c%0d: got %h expected a5", c, SRAM_DQ_O); else pass_cnt++;
                    total_cnt++; if (SRAM_A !== 16'h8000) $display("FAIL write_addr c%0d: got %h expected 8000", c, SRAM_A); else pass_cnt++;
                end
                total_cnt++; if (SRAM_OE_N !== 1'b1) $display("FAIL write_oe_n c%0d: got %b expected 1", c, SRAM_OE_N); else pass_cnt++;
                exp = (c == 8);
                total_cnt++; if (HOLD !== exp) $display("FAIL write_hold c%0d: got %b expected %b", c, HOLD, exp); else pass_cnt++;
            end
            if (c == 8) begin
                total_cnt++; if (CPU_DI !== 8'h18) $display("FAIL write_cpu_di_kept: got %h expected 18", CPU_DI); else pass_cnt++;
                RUN = 1'b0; CPU_W = 1'b0;
            end
        end
        total_cnt++; if (we_low !== 2) $display("FAIL write_we_width: got %0d expected 2", we_low); else pass_cnt++;
        total_cnt++; if (WP_FAULT !== 1'b0) $display("FAIL write_wp_fault: got %b expected 0", WP_FAULT); else pass_cnt++;
    endtask

    task automatic test_rom_write;
        logic exp;
        do_reset();
        CPU_A = 16'h0100; CPU_DO = 8'h5A; CPU_W = 1'b1; RUN = 1'b1; RESET = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = (c == 4);
            total_cnt++; if (HOLD !== exp) $display("FAIL rom_hold c%0d: got %b expected %b", c, HOLD, exp); else pass_cnt++;
`ifdef Z80_MEMCTL_ROM_WP_EN
            total_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL rom_we_n c%0d: got %b expected 1", c, SRAM_WE_N); else pass_cnt++;
            total_cnt++; if (SRAM_DQ_OE !== 1'b0) $display("FAIL rom_dq_oe c%0d: got %b expected 0", c, SRAM_DQ_OE); else pass_cnt++;
            if (c >= 2) begin
                total_cnt++; if (WP_FAULT !== 1'b1) $display("FAIL rom_wp_fault c%0d: got %b expected 1", c, WP_FAULT); else pass_cnt++;
            end
`else
            exp = !(c == 2 || c == 3);
            total_cnt++; if (SRAM_WE_N !== exp) $display("FAIL rom_we_n c%0d: got %b expected %b", c, SRAM_WE_N, exp); else pass_cnt++;
            total_cnt++; if (WP_FAULT !== 1'b0) $display("FAIL rom_wp_fault c%0d: got %b expected 0", c, WP_FAULT); else pass_cnt++;
`endif
            if (c == 4) begin
                RUN = 1'b0; CPU_W = 1'b0;
            end
        end
    endtask

    task automatic test_run_drop;
        logic exp;
        do_reset();
        CPU_A = 16'h00FF; CPU_W = 1'b0; RUN = 1'b1; RESET = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 2) RUN = 1'b0;
            exp = (c == 4 || c == 11);
            total_cnt++; if (HOLD !== exp) $display("FAIL run_drop_hold c%0d: got %b expected %b", c, HOLD, exp); else pass_cnt++;
            exp = !(c == 2 || c == 3 || c == 9 || c == 10);
            total_cnt++; if (SRAM_OE_N !== exp) $display("FAIL run_drop_oe_n c%0d: got %b expected %b", c, SRAM_OE_N, exp); else pass_cnt++;
            if (c == 4) begin
                total_cnt++; if (CPU_DI !== 8'hC1) $display("FAIL run_drop_data: got %h expected c1", CPU_DI); else pass_cnt++;
            end
            if (c == 7) RUN = 1'b1;
        end
        RUN = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        CPU_A = 16'h1234; CPU_W = 1'b0; RUN = 1'b1; RESET = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 4) begin
                CPU_A = 16'h0100; CPU_DO = 8'h77; CPU_W = 1'b1;
            end
            if (c == 8) begin
                CPU_A = 16'h9000; CPU_DO = 8'h3C;
            end
            if (c == 10) begin
                total_cnt++; if (SRAM_WE_N !== 1'b0) $display("FAIL mid_pre_we_n: got %b expected 0", SRAM_WE_N); else pass_cnt++;
                total_cnt++; if (CPU_DI !== 8'h18) $display("FAIL mid_pre_cpu_di: got %h expected 18", CPU_DI); else pass_cnt++;
`ifdef Z80_MEMCTL_ROM_WP_EN
                total_cnt++; if (WP_FAULT !== 1'b1) $display("FAIL mid_pre_wp_fault: got %b expected 1", WP_FAULT); else pass_cnt++;
`endif
                RESET = 1'b1;
            end
            if (c == 11) begin
                total_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL mid_we_n: got %b expected 1", SRAM_WE_N); else pass_cnt++;
                total_cnt++; if (SRAM_OE_N !== 1'b1) $display("FAIL mid_oe_n: got %b expected 1", SRAM_OE_N); else pass_cnt++;
                total_cnt++; if (SRAM_DQ_OE !== 1'b0) $display("FAIL mid_dq_oe: got %b expected 0", SRAM_DQ_OE); else pass_cnt++;
                total_cnt++; if (HOLD !== 1'b0) $display("FAIL mid_hold: got %b expected 0", HOLD); else pass_cnt++;
                total_cnt++; if (SRAM_A !== 16'h0000) $display("FAIL mid_sram_a: got %h expected 0000", SRAM_A); else pass_cnt++;
                total_cnt++; if (CPU_DI !== 8'h00) $display("FAIL mid_cpu_di: got %h expected 00", CPU_DI); else pass_cnt++;
                total_cnt++; if (WP_FAULT !== 1'b0) $display("FAIL mid_wp_fault: got %b expected 0", WP_FAULT); else pass_cnt++;
            end
        end
        RUN = 1'b0; CPU_W = 1'b0;
    endtask

    task automatic test_back_to_back;
        int pulses, first, last, bad_gap, data_err;
        pulses = 0; first = 0; last = 0; bad_gap = 0; data_err = 0;
        reset7 = 1'b1; run7 = 1'b0; w7 = 1'b0; a7 = 16'h0042; do7 = 8'h00;
        repeat (3) tick();
        reset7 = 1'b0; run7 = 1'b1;
        for (int c = 1; c <= 930; c++) begin
            tick();
            if (hold7) begin
                pulses++;
                if (pulses == 1) first = c;
                else if (c - last != 9) bad_gap++;
                if (di7 !== sram_data(a7)) data_err++;
                last = c;
                a7 = a7 + 16'h0123;
                if (pulses == 100) run7 = 1'b0;
            end
        end
        total_cnt++; if (pulses !== 100) $display("FAIL b2b_pulses: got %0d expected 100", pulses); else pass_cnt++;
        total_cnt++; if (first !== 9) $display("FAIL b2b_first: got %0d expected 9", first); else pass_cnt++;
        total_cnt++; if (last !== 900) $display("FAIL b2b_last: got %0d expected 900", last); else pass_cnt++;
        total_cnt++; if (bad_gap !== 0) $display("FAIL b2b_gaps: got %0d bad gaps expected 0", bad_gap); else pass_cnt++;
        total_cnt++; if (data_err !== 0) $display("FAIL b2b_data: got %0d bad reads expected 0", data_err); else pass_cnt++;
    endtask

    initial begin
        RESET = 1'b1; RUN = 1'b0; CPU_W = 1'b0; CPU_A = '0; CPU_DO = '0;
        reset7 = 1'b1; run7 = 1'b0; w7 = 1'b0; a7 = '0; do7 = '0;
        test_reset();
        test_first_read();
        test_write();
        test_rom_write();
        test_run_drop();
        test_reset_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
